// File: rtl/spi_cmd_deframer.sv
`default_nettype none
// ============================================================================
// Module   : spi_cmd_deframer
// Purpose  : Turns the synchronized SPI byte stream from the host into
//            committed command frames. A frame is a header byte, which carries
//            the command code in bits [4:1], followed by a fixed number of
//            parameter bytes and, for the streaming command only, any number
//            of payload bytes.
//            A command is committed only when its frame is complete and chip
//            select has risen. Short or overlong frames are discarded.
//            Payload bytes of the streaming command are forwarded one byte at
//            a time as they arrive.
// Ports    : clk_i          system clock
//            reset_i        synchronous reset, active high
//            ncsSync_i      chip select, already synchronized, active low
//            byteValid_i    one-cycle pulse: new byte on byteData_i
//            byteData_i     received SPI byte
//            cmd_o          committed command code, held until the next commit
//            cmdValid_o     one-cycle commit strobe
//            params_o       8 x 16-bit parameter words, word k = [16k+15:16k]
//            streamData_o   payload byte of a streaming frame
//            streamValid_o  one-cycle strobe per payload byte
//            fifoClr_o      one-cycle pulse at each frame start
//            frameErr_o     one-cycle pulse when a frame is discarded
//            errCnt_o       saturating count of discarded frames
// Config   : FRAME_CHECKSUM_EN - when defined, each frame carries one checksum
//            byte after the last parameter byte. The checksum is the XOR of
//            the header and all parameter bytes.
// Revision : 1.0 - initial release
// ============================================================================
module spi_cmd_deframer #(
    parameter int unsigned PARAM_BYTES      = 8,
    parameter int unsigned LONG_CMD         = 10,
    parameter int unsigned LONG_PARAM_BYTES = 16,
    parameter int unsigned STREAM_CMD       = 8
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         ncsSync_i,
    input  logic         byteValid_i,
    input  logic [7:0]   byteData_i,
    output logic [3:0]   cmd_o,
    output logic         cmdValid_o,
    output logic [127:0] params_o,
    output logic [7:0]   streamData_o,
    output logic         streamValid_o,
    output logic         fifoClr_o,
    output logic         frameErr_o,
    output logic [7:0]   errCnt_o
);

    localparam logic [3:0] c_longCmd   = 4'(LONG_CMD);
    localparam logic [3:0] c_streamCmd = 4'(STREAM_CMD);
    localparam logic [4:0] c_nbNormal  = 5'(PARAM_BYTES);
    localparam logic [4:0] c_nbLong    = 5'(LONG_PARAM_BYTES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR    = 3'd1,
        S_PARAM  = 3'd2,
        S_CHK    = 3'd3,
        S_TAIL   = 3'd4,
        S_COMMIT = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cmdBuf_q, cmdBuf_d;
    logic [4:0]    byteCnt_q, byteCnt_d;
    logic [4:0]    nBytes_q, nBytes_d;
    logic [15:0]   shadow_q [8];
    logic [15:0]   shadow_d [8];
    logic [127:0]  shadowFlat;

    logic [3:0]    cmd_q, cmd_d;
    logic          cmdValid_q, cmdValid_d;
    logic [127:0]  params_q, params_d;
    logic [7:0]    streamData_q, streamData_d;
    logic          streamValid_q, streamValid_d;
    logic          fifoClr_q, fifoClr_d;
    logic          frameErr_q, frameErr_d;
    logic [7:0]    errCnt_q, errCnt_d;

`ifdef FRAME_CHECKSUM_EN
    logic [7:0]    chk_q, chk_d;
`endif

    // Flattened view of the shadow words, loaded into params at commit.
    generate
        for (genvar k = 0; k < 8; k++) begin : g_pack
            assign shadowFlat[16*k +: 16] = shadow_q[k];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        cmdBuf_d      = cmdBuf_q;
        byteCnt_d     = byteCnt_q;
        nBytes_d      = nBytes_q;
        shadow_d      = shadow_q;
        cmd_d         = cmd_q;
        params_d      = params_q;
        cmdValid_d    = 1'b0;
        streamData_d  = streamData_q;
        streamValid_d = 1'b0;
        fifoClr_d     = 1'b0;
        frameErr_d    = 1'b0;
`ifdef FRAME_CHECKSUM_EN
        chk_d         = chk_q;
`endif

        // Chip select has priority over a byte arriving in the same cycle.
        // Any such byte is dropped.
        case (state_q)
            S_IDLE: begin
                if (!ncsSync_i) begin
                    state_d   = S_HDR;
                    fifoClr_d = 1'b1;
                end
            end

            S_HDR: begin
                if (ncsSync_i) begin
                    // Empty select: chip select went low and high with no
                    // header byte. This is not an error.
                    state_d = S_IDLE;
                end else if (byteValid_i) begin
                    cmdBuf_d  = byteData_i[4:1];
                    byteCnt_d = 5'd0;
                    nBytes_d  = (byteData_i[4:1] == c_longCmd) ? c_nbLong : c_nbNormal;
`ifdef FRAME_CHECKSUM_EN
                    chk_d     = byteData_i;
`endif
                    state_d   = S_PARAM;
                end
            end

            S_PARAM: begin
                if (ncsSync_i) begin
                    state_d    = S_IDLE;
                    frameErr_d = 1'b1;
                end else if (byteValid_i) begin
                    // Bytes fill the words little-endian. A legal frame has
                    // at most 16 bytes, so byteCnt[3:1] is always in range.
                    if (byteCnt_q[0]) begin
                        shadow_d[byteCnt_q[3:1]][15:8] = byteData_i;
                    end else begin
                        shadow_d[byteCnt_q[3:1]][7:0] = byteData_i;
                    end
                    byteCnt_d = byteCnt_q + 5'd1;
`ifdef FRAME_CHECKSUM_EN
                    chk_d     = chk_q ^ byteData_i;
`endif
                    if (byteCnt_q == nBytes_q - 5'd1) begin
`ifdef FRAME_CHECKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_TAIL;
`endif
                    end
                end
            end

`ifdef FRAME_CHECKSUM_EN
            S_CHK: begin
                if (ncsSync_i) begin
                    state_d    = S_IDLE;
                    frameErr_d = 1'b1;
                end else if (byteValid_i) begin
                    if (byteData_i == chk_q) begin
                        state_d = S_TAIL;
                    end else begin
                        state_d    = S_IDLE;
                        frameErr_d = 1'b1;
                    end
                end
            end
`endif

            S_TAIL: begin
                if (ncsSync_i) begin
                    // Load the commit registers here so that cmd and params
                    // are valid in the same cycle as the commit strobe.
                    state_d    = S_COMMIT;
                    cmd_d      = cmdBuf_q;
                    params_d   = shadowFlat;
                    cmdValid_d = 1'b1;
                end else if (byteValid_i) begin
                    if (cmdBuf_q == c_streamCmd) begin
                        streamData_d  = byteData_i;
                        streamValid_d = 1'b1;
                    end else begin
                        // Extra byte after a non-streaming frame: the frame
                        // is overlong.
                        state_d    = S_IDLE;
                        frameErr_d = 1'b1;
                    end
                end
            end

            S_COMMIT: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        errCnt_d = errCnt_q;
        if (frameErr_d && (errCnt_q != 8'hFF)) begin
            errCnt_d = errCnt_q + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            cmdBuf_q      <= 4'd0;
            byteCnt_q     <= 5'd0;
            nBytes_q      <= 5'd0;
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= 16'd0;
            end
            cmd_q         <= 4'd0;
            cmdValid_q    <= 1'b0;
            params_q      <= 128'd0;
            streamData_q  <= 8'd0;
            streamValid_q <= 1'b0;
            fifoClr_q     <= 1'b0;
            frameErr_q    <= 1'b0;
            errCnt_q      <= 8'd0;
`ifdef FRAME_CHECKSUM_EN
            chk_q         <= 8'd0;
`endif
        end else begin
            state_q       <= state_d;
            cmdBuf_q      <= cmdBuf_d;
            byteCnt_q     <= byteCnt_d;
            nBytes_q      <= nBytes_d;
            shadow_q      <= shadow_d;
            cmd_q         <= cmd_d;
            cmdValid_q    <= cmdValid_d;
            params_q      <= params_d;
            streamData_q  <= streamData_d;
            streamValid_q <= streamValid_d;
            fifoClr_q     <= fifoClr_d;
            frameErr_q    <= frameErr_d;
            errCnt_q      <= errCnt_d;
`ifdef FRAME_CHECKSUM_EN
            chk_q         <= chk_d;
`endif
        end
    end

    assign cmd_o         = cmd_q;
    assign cmdValid_o    = cmdValid_q;
    assign params_o      = params_q;
    assign streamData_o  = streamData_q;
    assign streamValid_o = streamValid_q;
    assign fifoClr_o     = fifoClr_q;
    assign frameErr_o    = frameErr_q;
    assign errCnt_o      = errCnt_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_deframer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_cmd_deframer
// Purpose  : Self-checking bench for spi_cmd_deframer. It covers directed
//            frames and randomized frames. A frame-level reference model
//            predicts the commits, errors, stream bytes and held outputs.
//            The bench also builds and checks the checksum byte when
//            FRAME_CHECKSUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_cmd_deframer;

    localparam int PB         = 8;
    localparam int LONG_CMD   = 10;
    localparam int LPB        = 16;
    localparam int STREAM_CMD = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         ncs = 1'b1;
    logic         bv = 1'b0;
    logic [7:0]   bd = 8'd0;
    logic [3:0]   cmd;
    logic         cmdValid;
    logic [127:0] params;
    logic [7:0]   streamData;
    logic         streamValid;
    logic         fifoClr;
    logic         frameErr;
    logic [7:0]   errCnt;

    spi_cmd_deframer dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .ncsSync_i     (ncs),
        .byteValid_i   (bv),
        .byteData_i    (bd),
        .cmd_o         (cmd),
        .cmdValid_o    (cmdValid),
        .params_o      (params),
        .streamData_o  (streamData),
        .streamValid_o (streamValid),
        .fifoClr_o     (fifoClr),
        .frameErr_o    (frameErr),
        .errCnt_o      (errCnt)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0]  m_shadow [8];
    logic [3:0]   m_cmd    = 4'd0;
    logic [127:0] m_params = 128'd0;
    int           m_err    = 0;
    int           e_commit, e_err, e_clr;
    logic [7:0]   e_stream [$];
    logic [7:0]   tx_q [$];

    // Predicts one frame (tx_q, with header first) from the framing rules.
    task automatic model_frame();
        logic [3:0] c;
        int         nb;
        int         pos;
        logic [7:0] x;
        bit         err;
        e_commit = 0;
        e_err    = 0;
        e_clr    = 1;
        e_stream.delete();
        if (tx_q.size() == 0) return;
        c   = tx_q[0][4:1];
        nb  = (c == 4'(LONG_CMD)) ? LPB : PB;
        x   = tx_q[0];
        err = 0;
        for (int i = 1; i <= nb && i < tx_q.size(); i++) begin
            if (((i - 1) % 2) == 0) m_shadow[(i - 1) / 2][7:0]  = tx_q[i];
            else                    m_shadow[(i - 1) / 2][15:8] = tx_q[i];
            x ^= tx_q[i];
        end
        pos = nb + 1;
        if (tx_q.size() < pos) err = 1;
`ifdef FRAME_CHECKSUM_EN
        else if (tx_q.size() == pos) err = 1;
        else if (tx_q[pos] !== x) begin err = 1; e_clr = 2; end
        else pos++;
`endif
        if (!err) begin
            if (c == 4'(STREAM_CMD)) begin
                for (int i = pos; i < tx_q.size(); i++) e_stream.push_back(tx_q[i]);
            end else if (tx_q.size() > pos) begin
                // Error while select is still low: the design re-enters the
                // header state, which gives a second frame-start pulse.
                err   = 1;
                e_clr = 2;
            end
        end
        if (err) begin
            e_err = 1;
            if (m_err < 255) m_err++;
        end else begin
            e_commit = 1;
            m_cmd    = c;
            for (int k = 0; k < 8; k++) m_params[16*k +: 16] = m_shadow[k];
        end
    endtask

    // ---------------- monitor ----------------
    int           mon_commit = 0, mon_err = 0, mon_clr = 0, mon_stab = 0;
    int           mon_stream_at_commit = -1;
    logic [7:0]   mon_stream [$];
    logic [3:0]   prev_cmd;
    logic [127:0] prev_params;

    always @(negedge clk) begin
        if (!reset) begin
            if (cmdValid) begin
                mon_commit++;
                mon_stream_at_commit = mon_stream.size();
            end else if (cmd !== prev_cmd || params !== prev_params) begin
                mon_stab++;
            end
            if (frameErr)    mon_err++;
            if (fifoClr)     mon_clr++;
            if (streamValid) mon_stream.push_back(streamData);
        end
        prev_cmd    = cmd;
        prev_params = params;
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bv = 1'b1;
        bd = b;
        @(negedge clk);
        bv = 1'b0;
        bd = 8'($urandom);
        idle($urandom_range(0, 2));
    endtask

    task automatic add_chk();
`ifdef FRAME_CHECKSUM_EN
        logic [7:0] x = 8'd0;
        foreach (tx_q[i]) x ^= tx_q[i];
        tx_q.push_back(x);
`endif
    endtask

    task automatic push_params(input int n);
        for (int i = 0; i < n; i++) tx_q.push_back(8'($urandom));
    endtask

    task automatic run_frame();
        int b_commit = mon_commit, b_err = mon_err, b_clr = mon_clr, b_stab = mon_stab;
        int b_stream = mon_stream.size();
        mon_stream_at_commit = -1;
        model_frame();
        ncs = 1'b0;
        idle(2);
        foreach (tx_q[i]) send_byte(tx_q[i]);
        idle(2 + $urandom_range(0, 1));
        ncs = 1'b1;
        idle(4);
        check("commits", mon_commit - b_commit, e_commit);
        check("errs", mon_err - b_err, e_err);
        check("fifoClr", mon_clr - b_clr, e_clr);
        check("streamLen", mon_stream.size() - b_stream, e_stream.size());
        for (int i = 0; i < e_stream.size() && (b_stream + i) < mon_stream.size(); i++)
            check("streamByte", mon_stream[b_stream + i], e_stream[i]);
        if (e_commit != 0)
            check("streamBeforeCommit", mon_stream_at_commit, b_stream + e_stream.size());
        check("cmd", cmd, m_cmd);
        check("params", params, m_params);
        check("errCnt", errCnt, m_err);
        check("stable", mon_stab - b_stab, 0);
    endtask

    task automatic gen_random();
        int         kind = $urandom_range(0, 5);
        logic [7:0] h    = 8'($urandom);
        int         nb;
        tx_q.delete();
        if (kind == 5) return;
        if (kind == 3) h[4:1] = 4'(STREAM_CMD);
        else if ($urandom_range(0, 3) == 0) h[4:1] = 4'(LONG_CMD);
        if (kind == 4 && h[4:1] == 4'(STREAM_CMD)) h[4:1] = 4'd3;
        nb = (h[4:1] == 4'(LONG_CMD)) ? LPB : PB;
        tx_q.push_back(h);
        case (kind)
            1: push_params($urandom_range(0, nb));
            2: begin
                push_params(nb);
`ifdef FRAME_CHECKSUM_EN
                if ($urandom_range(0, 1) == 1) tx_q.push_back(8'($urandom));
                else add_chk();
`endif
            end
            3: begin push_params(nb); add_chk(); push_params($urandom_range(0, 4)); end
            4: begin push_params(nb); add_chk(); push_params(1); end
            default: begin push_params(nb); add_chk(); end
        endcase
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int k = 0; k < 8; k++) m_shadow[k] = 16'd0;
        idle(3);
        check("rst_cmd", cmd, 4'd0);
        check("rst_params", params, 128'd0);
        check("rst_strobes", {cmdValid, streamValid, fifoClr, frameErr}, 4'd0);
        check("rst_errCnt", errCnt, 8'd0);
        reset = 1'b0;
        idle(2);

        // Basic cmd 2 frame
        tx_q = '{8'h04, 8'h05, 8'h00, 8'h05, 8'h00, 8'h05, 8'h00, 8'h05, 8'h00};
        add_chk();
        run_frame();
        check("t1_word0", params[15:0], 16'h0005);
        check("t1_cmd", cmd, 4'd2);

        // Long command with 16 parameter bytes
        tx_q = '{8'h14};
        for (int i = 1; i <= 16; i++) tx_q.push_back(8'(i));
        add_chk();
        run_frame();
        check("t2_word0", params[15:0], 16'h0201);
        check("t2_word7", params[127:112], 16'h100F);

        // Streaming command with a 3-byte payload
        tx_q = '{8'h10};
        push_params(8);
        add_chk();
        tx_q.push_back(8'hAA); tx_q.push_back(8'h55); tx_q.push_back(8'h3C);
        run_frame();
        check("t3_cmd", cmd, 4'd8);

        // Short frame, then an overlong frame
        tx_q = '{8'h02, 8'h11, 8'h22, 8'h33};
        run_frame();
        check("t4_errCnt", errCnt, 8'd1);
        tx_q = '{8'h02};
        push_params(8);
        add_chk();
        push_params(1);
        run_frame();
        check("t5_errCnt", errCnt, 8'd2);

        // Saturate the error counter with short frames
        for (int f = 0; f < 300; f++) begin
            tx_q = '{8'h02, 8'h01};
            run_frame();
        end
        check("t5_errSat", errCnt, 8'd255);

        // Reset in the middle of a parameter run
        tx_q = '{8'h04, 8'h11, 8'h22, 8'h33};
        ncs = 1'b0;
        idle(2);
        foreach (tx_q[i]) send_byte(tx_q[i]);
        reset = 1'b1;
        idle(2);
        check("t6_rst_cmd", cmd, 4'd0);
        check("t6_rst_params", params, 128'd0);
        check("t6_rst_errCnt", errCnt, 8'd0);
        check("t6_rst_strobes", {cmdValid, streamValid, fifoClr, frameErr}, 4'd0);
        ncs = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(3);
        for (int k = 0; k < 8; k++) m_shadow[k] = 16'd0;
        m_cmd    = 4'd0;
        m_params = 128'd0;
        m_err    = 0;
        tx_q = '{8'h04, 8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6, 8'h07, 8'h18};
        add_chk();
        run_frame();
        check("t6_word3", params[63:48], 16'h1807);
        check("t6_word4", params[79:64], 16'h0000);

`ifdef FRAME_CHECKSUM_EN
        // cmd 2 frame with a corrupted checksum byte
        tx_q = '{8'h04};
        push_params(8);
        add_chk();
        tx_q[tx_q.size() - 1] = tx_q[tx_q.size() - 1] ^ 8'h01;
        run_frame();
`endif

        for (int f = 0; f < 80; f++) begin
            gen_random();
            run_frame();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
